// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame sequencer.
//   - default image geometry and drain timeout
//   - FSM state encoding (plain constants plus the matching enum type)
//   - constant functions for the expected output count and counter widths
package sobel_pkg;

  localparam int DEF_IMG_W     = 512;
  localparam int DEF_IMG_H     = 512;
  localparam int DEF_FLUSH_LEN = 512;
  localparam int DEF_DRAIN_TO  = 4096;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_FLUSH = ST_FLUSH,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_e;

  // A 3x3 valid-only convolution loses one pixel on each border.
  function automatic int calc_out_pix(input int img_w, input int img_h);
    return (img_w - 2) * (img_h - 2);
  endfunction

  // Wide enough to hold the terminal value itself, so nothing wraps in a frame.
  function automatic int cnt_width(input int term);
    return $clog2(term) + 1;
  endfunction

endpackage

// File: rtl/sobel_beat_cnt.sv
// Terminal-count beat counter.
//   Clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   clr    : synchronous clear (wins over en)
//   en     : count one beat
//   at_term: count currently equals TERM-1 (the next enabled beat is the last)
module sobel_beat_cnt
  import sobel_pkg::*;
#(
  parameter int TERM = 16
) (
  input  logic Clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_term
);

  localparam int W = cnt_width(TERM);
  // TERM = 0 means the counter is never used; park the compare value at 0.
  localparam logic [W-1:0] TERM_M1 = (TERM > 0) ? W'(TERM - 1) : '0;

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d takes its hold value first, so every path assigns it and no
  // latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: flops are updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term = (cnt_q == TERM_M1);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer between the DMA input stream and the Sobel datapath.
//   Clk, rst          : clock and synchronous active-high reset
//   start             : one-cycle frame request, honoured only when idle
//   threshold_in      : threshold captured on an accepted start
//   thresh_out        : latched threshold toward the convolution block
//   s_valid/s_data    : DMA pixel stream in; s_ready is its ready
//   dma_ready         : downstream backpressure; gates input and flush beats
//   pix_valid/pix_data: registered pixel stream to the window builder
//   conv_valid        : one convolution result produced this cycle
//   out_last          : marks the final convolution result of the frame
//   busy/done         : not idle / one-cycle end-of-frame pulse
//   err_timeout       : sticky, drain phase saw no output for too long
//   err_extra         : sticky, a convolution result arrived outside a frame
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int FLUSH_LEN = DEF_FLUSH_LEN,
  parameter int OUT_PIX   = calc_out_pix(IMG_W, IMG_H),
  parameter int DRAIN_TO  = DEF_DRAIN_TO
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] threshold_in,
  output logic [7:0] thresh_out,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       dma_ready,
  output logic       pix_valid,
  output logic [7:0] pix_data,
  input  logic       conv_valid,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       err_extra
);

  localparam int NPIX = IMG_W * IMG_H;

  state_e     state_q, state_d;
  logic [7:0] thresh_q, thresh_d;
  logic [7:0] pix_data_q, pix_data_d;
  logic       pix_valid_q, pix_valid_d;
  logic       err_timeout_q, err_timeout_d;
  logic       err_extra_q, err_extra_d;

  logic frame_clr, active, accept, flush_emit, out_hit, idle_tick, timeout;
  logic in_last, flush_last, out_term, idle_term;

  assign frame_clr  = (state_q == S_IDLE) && start;
  assign active     = (state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
  assign s_ready    = (state_q == S_RUN) && dma_ready;
  assign accept     = s_ready && s_valid;
  assign flush_emit = (state_q == S_FLUSH) && dma_ready;
  assign out_hit    = active && conv_valid;
  assign out_last   = out_hit && out_term;
  // Only silent drain cycles count toward the timeout; any output restarts it.
  assign idle_tick  = (state_q == S_DRAIN) && !conv_valid;
  assign timeout    = idle_tick && idle_term;

  sobel_beat_cnt #(.TERM(NPIX)) u_in_cnt (
    .Clk(Clk), .rst(rst), .clr(frame_clr), .en(accept), .at_term(in_last)
  );

  sobel_beat_cnt #(.TERM(FLUSH_LEN)) u_flush_cnt (
    .Clk(Clk), .rst(rst), .clr(frame_clr), .en(flush_emit), .at_term(flush_last)
  );

  sobel_beat_cnt #(.TERM(OUT_PIX)) u_out_cnt (
    .Clk(Clk), .rst(rst), .clr(frame_clr), .en(out_hit), .at_term(out_term)
  );

  sobel_beat_cnt #(.TERM(DRAIN_TO)) u_idle_cnt (
    .Clk(Clk), .rst(rst), .clr(frame_clr || conv_valid), .en(idle_tick), .at_term(idle_term)
  );

  always_comb begin
    state_d       = state_q;
    thresh_d      = thresh_q;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    err_timeout_d = err_timeout_q;
    err_extra_d   = err_extra_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RUN;
          thresh_d      = threshold_in;
          err_timeout_d = 1'b0;
          err_extra_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          pix_valid_d = 1'b1;
          pix_data_d  = s_data;
          if (in_last) begin
            if (FLUSH_LEN > 0) state_d = S_FLUSH;
            else               state_d = S_DRAIN;
          end
        end
      end
      S_FLUSH: begin
        if (flush_emit) begin
          pix_valid_d = 1'b1;
          pix_data_d  = '0;
          if (flush_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The final output beat outranks a timeout landing on the same cycle.
        if (timeout && !out_last) begin
          err_timeout_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The last expected result ends the frame from any active state,
    // abandoning whatever flush is still outstanding.
    if (out_last) state_d = S_DONE;

    // A stray result also beats the clear from a same-cycle start.
    if (!active && conv_valid) err_extra_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      thresh_q      <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      err_timeout_q <= 1'b0;
      err_extra_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      thresh_q      <= thresh_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      err_timeout_q <= err_timeout_d;
      err_extra_q   <= err_extra_d;
    end
  end

  assign thresh_out  = thresh_q;
  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign err_timeout = err_timeout_q;
  assign err_extra   = err_extra_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl on a small 8x4 image.
// A transaction-level reference model tracks the frame phase and beat counts
// from the behavioural rules; every cycle the DUT outputs are compared to it,
// and each scenario adds frame-level checks (beat totals, pixel stream, pulses).
module tb_sobel_frame_ctrl;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int FL   = 8;
  localparam int OP   = 12;
  localparam int DT   = 16;
  localparam int NPIX = W * H;

  logic       Clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] threshold_in;
  logic [7:0] thresh_out;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       dma_ready;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       conv_valid;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       err_extra;

  sobel_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .FLUSH_LEN(FL), .OUT_PIX(OP), .DRAIN_TO(DT)
  ) dut (
    .Clk(Clk), .rst(rst), .start(start), .threshold_in(threshold_in),
    .thresh_out(thresh_out), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .dma_ready(dma_ready), .pix_valid(pix_valid),
    .pix_data(pix_data), .conv_valid(conv_valid), .out_last(out_last),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_extra(err_extra)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_FLUSH, M_DRAIN, M_DONE} mph_e;
  mph_e       m_ph;
  int         m_in, m_fl, m_out, m_idle;
  logic [7:0] m_thr, m_pd;
  bit         m_pv, m_to, m_ex;

  // frame statistics observed from the DUT
  int         f_beats, f_last, f_done;
  logic [7:0] obs_q[$];

  task automatic model_reset();
    m_ph = M_IDLE; m_in = 0; m_fl = 0; m_out = 0; m_idle = 0;
    m_thr = '0; m_pd = '0; m_pv = 0; m_to = 0; m_ex = 0;
  endtask

  function automatic bit m_active();
    return (m_ph == M_RUN) || (m_ph == M_FLUSH) || (m_ph == M_DRAIN);
  endfunction

  task automatic model_advance();
    bit act;
    act  = m_active();
    m_pv = 0;
    case (m_ph)
      M_IDLE: if (start) begin
        m_ph = M_RUN; m_thr = threshold_in;
        m_in = 0; m_fl = 0; m_out = 0; m_idle = 0; m_to = 0; m_ex = 0;
      end
      M_RUN: if (s_valid && dma_ready) begin
        m_pv = 1; m_pd = s_data; m_in++;
        if (m_in == NPIX) begin
          if (FL > 0) m_ph = M_FLUSH;
          else        m_ph = M_DRAIN;
        end
      end
      M_FLUSH: if (dma_ready) begin
        m_pv = 1; m_pd = 8'h00; m_fl++;
        if (m_fl == FL) m_ph = M_DRAIN;
      end
      M_DRAIN: begin
        if (conv_valid) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == DT) begin m_to = 1; m_ph = M_DONE; end
        end
      end
      M_DONE: m_ph = M_IDLE;
      default: m_ph = M_IDLE;
    endcase
    if (act && conv_valid) begin
      m_out++;
      if (m_out == OP) m_ph = M_DONE;
    end
    if (!act && conv_valid) m_ex = 1;
  endtask

  task automatic check_outputs();
    bit act;
    act = m_active();
    check("s_ready",     32'(s_ready),     32'(m_ph == M_RUN && dma_ready));
    check("busy",        32'(busy),        32'(m_ph != M_IDLE));
    check("done",        32'(done),        32'(m_ph == M_DONE));
    check("out_last",    32'(out_last),    32'(act && conv_valid && m_out == OP - 1));
    check("pix_valid",   32'(pix_valid),   32'(m_pv));
    check("pix_data",    32'(pix_data),    32'(m_pd));
    check("thresh_out",  32'(thresh_out),  32'(m_thr));
    check("err_timeout", 32'(err_timeout), 32'(m_to));
    check("err_extra",   32'(err_extra),   32'(m_ex));
  endtask

  // One clock: inputs are already set; compare at the falling edge, then
  // advance the model and return just after the rising edge.
  task automatic step();
    @(negedge Clk);
    if (!rst) check_outputs();
    if (pix_valid) begin f_beats++; obs_q.push_back(pix_data); end
    if (out_last) f_last++;
    if (done)     f_done++;
    if (rst) model_reset();
    else     model_advance();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_thresh"},  32'(thresh_out),  32'h0);
    check({tag, "_s_ready"}, 32'(s_ready),     32'h0);
    check({tag, "_pv"},      32'(pix_valid),   32'h0);
    check({tag, "_pd"},      32'(pix_data),    32'h0);
    check({tag, "_last"},    32'(out_last),    32'h0);
    check({tag, "_busy"},    32'(busy),        32'h0);
    check({tag, "_done"},    32'(done),        32'h0);
    check({tag, "_eto"},     32'(err_timeout), 32'h0);
    check({tag, "_eex"},     32'(err_extra),   32'h0);
  endtask

  // rmode: 0 = dma_ready always 1, 1 = toggles every cycle, 2 = random
  task automatic run_frame(input logic [7:0] thr, input int rmode, input int conv_target,
                           input bit seq_data, input bit poke_start, input bit early_ok);
    int cyc;
    int conv_sent;
    bit allow;
    f_beats = 0; f_last = 0; f_done = 0; obs_q.delete();
    conv_sent = 0; cyc = 0;
    start = 1'b1; threshold_in = thr; s_valid = 1'b0; conv_valid = 1'b0; dma_ready = 1'b1;
    step();
    start = 1'b0;
    check("start_thr", 32'(thresh_out), 32'(thr));
    check("start_clr_extra", 32'(err_extra), 32'h0);
    while (m_ph != M_IDLE && cyc < 3000) begin
      case (rmode)
        0:       dma_ready = 1'b1;
        1:       dma_ready = cyc[0];
        default: dma_ready = 1'($urandom_range(0, 1));
      endcase
      s_valid = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      s_data  = seq_data ? 8'(m_in) : 8'($urandom);
      allow   = (conv_sent < conv_target) && m_active();
      if (allow && !early_ok && m_ph != M_DRAIN)
        allow = (m_in >= 16) && (conv_sent < conv_target - 1);
      conv_valid   = allow && ((m_ph == M_DRAIN && m_idle >= 8) || $urandom_range(0, 2) == 0);
      start        = poke_start && (cyc == 5);
      threshold_in = poke_start ? 8'h99 : thr;
      step();
      if (conv_valid) conv_sent++;
      cyc++;
    end
    start = 1'b0; conv_valid = 1'b0; s_valid = 1'b0; threshold_in = 8'h00;
    check("frame_budget", 32'(cyc < 3000), 32'h1);
  endtask

  initial begin
    int k;
    model_reset();
    rst = 1'b1; start = 1'b0; threshold_in = '0; s_valid = 1'b0; s_data = '0;
    dma_ready = 1'b0; conv_valid = 1'b0;
    f_beats = 0; f_last = 0; f_done = 0;
    step(); step();
    rst = 1'b0;
    check_reset_vals("rst0");

    // 1. nominal frame
    run_frame(8'h40, 0, 12, 1'b1, 1'b0, 1'b0);
    check("s1_thr",   32'(thresh_out), 32'h40);
    check("s1_beats", 32'(f_beats),    32'(NPIX + FL));
    check("s1_last",  32'(f_last),     32'h1);
    check("s1_done",  32'(f_done),     32'h1);
    check("s1_busy",  32'(busy),       32'h0);
    check("s1_nobs",  32'(obs_q.size()), 32'(NPIX + FL));
    for (int i = 0; i < NPIX + FL && i < obs_q.size(); i++)
      check($sformatf("s1_pix%0d", i), 32'(obs_q[i]), (i < NPIX) ? 32'(i) : 32'h0);

    // 2. backpressure, dma_ready toggling
    run_frame(8'h41, 1, 12, 1'b1, 1'b0, 1'b0);
    check("s2_beats", 32'(f_beats), 32'(NPIX + FL));
    check("s2_done",  32'(f_done),  32'h1);
    for (int i = 0; i < NPIX && i < obs_q.size(); i++)
      check($sformatf("s2_pix%0d", i), 32'(obs_q[i]), 32'(i));

    // 3. drain timeout
    run_frame(8'h42, 0, 11, 1'b1, 1'b0, 1'b0);
    check("s3_eto",  32'(err_timeout), 32'h1);
    check("s3_last", 32'(f_last),      32'h0);
    check("s3_done", 32'(f_done),      32'h1);

    // 4. stray output while idle
    conv_valid = 1'b1; step();
    conv_valid = 1'b0; step();
    check("s4_eex",  32'(err_extra), 32'h1);
    check("s4_last", 32'(f_last),    32'h0);
    run_frame(8'h40, 0, 12, 1'b1, 1'b0, 1'b0);
    check("s4_next_last", 32'(f_last), 32'h1);
    check("s4_next_eex",  32'(err_extra), 32'h0);

    // 5. reset mid-frame after 10 pixels
    f_done = 0;
    start = 1'b1; threshold_in = 8'h55; step(); start = 1'b0;
    k = 0;
    while (m_in < 10 && k < 200) begin
      dma_ready = 1'b1; s_valid = 1'b1; s_data = 8'(m_in);
      step(); k++;
    end
    check("s5_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    s_valid = 1'b0;
    check_reset_vals("s5");
    step();
    check("s5_nodone", 32'(f_done), 32'h0);
    run_frame(8'h40, 0, 12, 1'b1, 1'b0, 1'b0);
    check("s5_beats", 32'(f_beats), 32'(NPIX + FL));
    check("s5_last",  32'(f_last),  32'h1);
    check("s5_done",  32'(f_done),  32'h1);

    // 6. start while busy is ignored
    run_frame(8'h40, 0, 12, 1'b1, 1'b1, 1'b0);
    check("s6_thr",  32'(thresh_out), 32'h40);
    check("s6_done", 32'(f_done),     32'h1);
    check("s6_last", 32'(f_last),     32'h1);

    // randomized frames, including early final beats and timeouts
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        conv_valid = 1'b1; step(); conv_valid = 1'b0;
      end
      step();
      run_frame(8'($urandom), 2, (f % 3 == 2) ? 9 : 12, 1'b0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      check($sformatf("rnd%0d_done", f), 32'(f_done), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
